buf_out_packer: RTL

- Upstream neighbour of the `master` output stage.
- Accepts one T_DATA_WIDTH data lane per cycle from the resizer core and packs lanes into M_KEEP_WIDTH-lane output entries.
- Queues completed entries in a DEPTH-entry FIFO.
- Presents the FIFO head to `master` through the existing `underflow` / `master_entry` / `master_entry_ready` interface.

---
 rtl/buf_out_packer.sv | 115 +++++++++++
 1 files changed

// File: rtl/buf_out_packer.sv
// buf_out_packer
//   Packs single data lanes from the resizer core into multi-lane output
//   entries and queues them in a small FIFO feeding the master stage.
//   Lane i of an entry sits at master_entry[i*(T_DATA_WIDTH+2) +: T_DATA_WIDTH+2],
//   laid out {data, keep, last}. Unfilled lanes of a committed entry are zero.
//
// Ports
//   clk                 rising-edge clock
//   rst                 synchronous active-high reset
//   in_valid/in_ready   lane handshake; in_ready depends only on registered level
//   in_data/in_last     lane payload and end-of-packet marker
//   underflow           FIFO empty (master_entry forced to zero)
//   master_entry        FIFO head, first-word-fall-through
//   master_entry_ready  pop head (ignored while underflow)
//   level               number of stored entries, 0..DEPTH
module buf_out_packer #(
    parameter  int M_KEEP_WIDTH     = 2,
    parameter  int T_DATA_WIDTH     = 1,
    parameter  int DEPTH            = 4,
    localparam int BUF_OUT_ENTRY_SZ = (2 + T_DATA_WIDTH) * M_KEEP_WIDTH,
    localparam int LEVEL_W          = $clog2(DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [T_DATA_WIDTH-1:0]     in_data,
    input  logic                        in_last,
    output logic                        underflow,
    output logic [BUF_OUT_ENTRY_SZ-1:0] master_entry,
    input  logic                        master_entry_ready,
    output logic [LEVEL_W-1:0]          level
);

    localparam int LANE_W = T_DATA_WIDTH + 2;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FILL_W = $clog2(M_KEEP_WIDTH + 1);

    logic [BUF_OUT_ENTRY_SZ-1:0] mem_q [DEPTH];
    logic [BUF_OUT_ENTRY_SZ-1:0] asm_q, asm_d, asm_next;
    logic [FILL_W-1:0]           fill_q, fill_d;
    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
    logic [LEVEL_W-1:0]          level_q, level_d;
    logic [LANE_W-1:0]           lane;
    logic                        accept;
    logic                        commit;
    logic                        pop;

    assign in_ready     = (level_q < LEVEL_W'(DEPTH));
    assign underflow    = (level_q == '0);
    assign level        = level_q;
    assign master_entry = underflow ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        accept   = in_valid && in_ready;
        pop      = master_entry_ready && !underflow;
        lane     = {in_data, 1'b1, in_last};

        // Assembly register only ever holds filled slots; everything above
        // fill is still zero from the last clear, which gives the padding.
        asm_next = asm_q;
        for (int i = 0; i < M_KEEP_WIDTH; i++) begin
            if (fill_q == FILL_W'(i)) begin
                asm_next[i*LANE_W +: LANE_W] = lane;
            end
        end

        commit   = accept && (in_last || (fill_q == FILL_W'(M_KEEP_WIDTH - 1)));

        asm_d    = asm_q;
        fill_d   = fill_q;
        if (commit) begin
            asm_d  = '0;
            fill_d = '0;
        end else if (accept) begin
            asm_d  = asm_next;
            fill_d = fill_q + FILL_W'(1);
        end

        wr_ptr_d = commit ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop    ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        level_d  = level_q;
        case ({commit, pop})
            2'b10:   level_d = level_q + LEVEL_W'(1);
            2'b01:   level_d = level_q - LEVEL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            asm_q    <= '0;
            fill_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            asm_q    <= asm_d;
            fill_q   <= fill_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: its contents are masked while level is zero.
    always_ff @(posedge clk) begin
        if (commit && !rst) begin
            mem_q[wr_ptr_q] <= asm_next;
        end
    end

endmodule
